// File: rtl/ws2812_frame_buffer.sv
// Double-buffered WS2812 pixel store: the control side writes the back bank while the
// serial interface streams the front bank. Bank swaps are atomic and a clear sweep resets the back bank.
module ws2812_frame_buffer #(
    parameter int                 NUM_LEDS  = 1000,
    parameter int                 ADDR_W    = 16,
    parameter int                 COLOR_W   = 24,
    parameter logic [COLOR_W-1:0] CLEAR_VAL = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_ready,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COLOR_W-1:0] rd_data,
    output logic               rd_dv,
    output logic               rd_oor,
    input  logic               swap_req,
    output logic               swap_done,
    output logic               front_sel,
    input  logic               clear_req,
    output logic               clear_busy
);

    localparam int                IDX_W     = $clog2(2 * NUM_LEDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_next;
    logic                swap_pend, swap_pend_next;
    logic                clear_lat, clear_lat_next;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_next;
    logic                swap_exec;

    logic [COLOR_W-1:0]  mem [2*NUM_LEDS];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [COLOR_W-1:0]  mem_wdata;
    logic                wr_hit;
    logic                rd_hit;
    logic [COLOR_W-1:0]  ram_q, ram_q2;
    logic                v1, v2, oor1, oor2;

    // Bank 0 occupies the low half of the RAM, bank 1 the high half.
    function automatic logic [IDX_W-1:0] bank_index(input logic bank, input logic [ADDR_W-1:0] addr);
        logic [IDX_W-1:0] base;
        base = bank ? IDX_W'(NUM_LEDS) : '0;
        return base + IDX_W'(addr);
    endfunction

    // A clear that coincides with a pending or new swap waits until the swap has happened.
    always_comb begin
        state_next     = state;
        clear_lat_next = clear_lat;
        clr_cnt_next   = clr_cnt;
        swap_exec      = 1'b0;
        case (state)
            IDLE: begin
                swap_exec = swap_pend;
                if ((clear_req || clear_lat) && !swap_pend && !swap_req) begin
                    state_next     = CLEAR;
                    clr_cnt_next   = '0;
                    clear_lat_next = 1'b0;
                end else if (clear_req) begin
                    clear_lat_next = 1'b1;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        swap_pend_next = swap_exec ? 1'b0 : (swap_pend | swap_req);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            swap_pend <= 1'b0;
            clear_lat <= 1'b0;
            clr_cnt   <= '0;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_next;
            swap_pend <= swap_pend_next;
            clear_lat <= clear_lat_next;
            clr_cnt   <= clr_cnt_next;
            front_sel <= front_sel ^ swap_exec;
            swap_done <= swap_exec;
        end
    end

    assign clear_busy = (state == CLEAR);
    assign wr_ready   = ~clear_busy;
    assign wr_hit     = wr_en && wr_ready && (wr_addr <= LAST_ADDR);
    assign rd_hit     = rd_en && (rd_addr <= LAST_ADDR);

    // The sweep and external writes share one port; only one can be active at a time.
    always_comb begin
        mem_we    = clear_busy | wr_hit;
        mem_waddr = bank_index(~front_sel, clear_busy ? clr_cnt : wr_addr);
        mem_wdata = clear_busy ? CLEAR_VAL : wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Unreset read pipeline keeps the RAM and its output register mappable to block RAM.
    always_ff @(posedge clk) begin
        if (rd_hit) begin
            ram_q <= mem[bank_index(front_sel, rd_addr)];
        end
        ram_q2 <= ram_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1      <= 1'b0;
            oor1    <= 1'b0;
            v2      <= 1'b0;
            oor2    <= 1'b0;
            rd_dv   <= 1'b0;
            rd_oor  <= 1'b0;
            rd_data <= '0;
        end else begin
            v1     <= rd_en;
            oor1   <= rd_en && !rd_hit;
            v2     <= v1;
            oor2   <= oor1;
            rd_dv  <= v2;
            rd_oor <= oor2;
            if (v2) begin
                rd_data <= oor2 ? '0 : ram_q2;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Self-checking bench for ws2812_frame_buffer: scenario tasks compared against an
// array model of both banks, the front selection and the pending swap.
module tb_ws2812_frame_buffer;

    localparam int                 NUM_LEDS  = 1000;
    localparam int                 ADDR_W    = 16;
    localparam int                 COLOR_W   = 24;
    localparam logic [COLOR_W-1:0] CLEAR_VAL = '0;

    logic               clk;
    logic               reset_n;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ready;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COLOR_W-1:0] rd_data;
    logic               rd_dv;
    logic               rd_oor;
    logic               swap_req;
    logic               swap_done;
    logic               front_sel;
    logic               clear_req;
    logic               clear_busy;

    ws2812_frame_buffer #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (ADDR_W),
        .COLOR_W  (COLOR_W),
        .CLEAR_VAL(CLEAR_VAL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_dv     (rd_dv),
        .rd_oor    (rd_oor),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .front_sel (front_sel),
        .clear_req (clear_req),
        .clear_busy(clear_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    logic [COLOR_W-1:0] model [2][NUM_LEDS];
    logic               mfront;

    typedef struct {
        int                 due;
        logic [COLOR_W-1:0] data;
        logic               oor;
    } exp_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t expect_read(input int addr, input int due);
        exp_t e;
        e.due = due;
        if (addr >= NUM_LEDS) begin
            e.data = '0;
            e.oor  = 1'b1;
        end else begin
            e.data = model[mfront][addr];
            e.oor  = 1'b0;
        end
        return e;
    endfunction

    task automatic write_px(input int addr, input logic [COLOR_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        step();
        wr_en = 1'b0;
        if (addr < NUM_LEDS) model[~mfront][addr] = data;
    endtask

    // Issues reads on consecutive cycles and expects each result exactly two edges later.
    task automatic read_stream(input int addrs[$], input string tag);
        exp_t q[$];
        exp_t e;
        logic dv_exp;
        int   n;
        n = addrs.size();
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(addrs[c]);
                q.push_back(expect_read(addrs[c], c + 2));
            end else begin
                rd_en = 1'b0;
            end
            step();
            dv_exp = (q.size() > 0 && q[0].due == c);
            checks++;
            if (rd_dv !== dv_exp)
                $display("[TB] FAIL %s rd_dv cycle %0d: got %b expected %b", tag, c, rd_dv, dv_exp);
            if (dv_exp) begin
                e = q.pop_front();
                checks += 2;
                if (rd_data !== e.data)
                    $display("[TB] FAIL %s rd_data cycle %0d: got %0h expected %0h", tag, c, rd_data, e.data);
                if (rd_oor !== e.oor)
                    $display("[TB] FAIL %s rd_oor cycle %0d: got %b expected %b", tag, c, rd_oor, e.oor);
                if (rd_data !== e.data) errors++;
                if (rd_oor !== e.oor) errors++;
            end else begin
                checks++;
                if (rd_oor !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s rd_oor idle cycle %0d: got %b expected 0", tag, c, rd_oor);
                end
            end
            if (rd_dv !== dv_exp) errors++;
        end
        rd_en = 1'b0;
    endtask

    task automatic readback(input string tag);
        int a[$];
        for (int i = 0; i < NUM_LEDS; i++) a.push_back(i);
        read_stream(a, tag);
    endtask

    task automatic do_swap(input string tag);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        checks += 2;
        if (front_sel !== mfront) begin
            errors++;
            $display("[TB] FAIL %s early front_sel: got %b expected %b", tag, front_sel, mfront);
        end
        if (swap_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s early swap_done: got %b expected 0", tag, swap_done);
        end
        step();
        mfront = ~mfront;
        checks += 2;
        if (front_sel !== mfront) begin
            errors++;
            $display("[TB] FAIL %s front_sel: got %b expected %b", tag, front_sel, mfront);
        end
        if (swap_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s swap_done: got %b expected 1", tag, swap_done);
        end
        step();
        checks++;
        if (swap_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s swap_done width: got %b expected 0", tag, swap_done);
        end
    endtask

    // Runs a sweep already started; optionally pokes a write to addr 3 and a swap mid-sweep.
    task automatic run_sweep(input string tag, input int wr_at, input int swap_at);
        int   busy;
        logic cb;
        busy = 0;
        cb   = ~mfront;
        while (clear_busy === 1'b1 && busy < 3 * NUM_LEDS) begin
            busy++;
            checks += 2;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s wr_ready during clear: got %b expected 0", tag, wr_ready);
            end
            if (front_sel !== mfront) begin
                errors++;
                $display("[TB] FAIL %s front_sel during clear: got %b expected %b", tag, front_sel, mfront);
            end
            wr_en    = (busy == wr_at);
            wr_addr  = ADDR_W'(3);
            wr_data  = 24'hABCDEF;
            swap_req = (busy == swap_at);
            step();
            wr_en    = 1'b0;
            swap_req = 1'b0;
        end
        checks += 2;
        if (busy != NUM_LEDS) begin
            errors++;
            $display("[TB] FAIL %s busy cycles: got %0d expected %0d", tag, busy, NUM_LEDS);
        end
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s wr_ready after clear: got %b expected 1", tag, wr_ready);
        end
        for (int a = 0; a < NUM_LEDS; a++) model[cb][a] = CLEAR_VAL;
        if (swap_at > 0) begin
            checks += 2;
            if (swap_done !== 1'b0 || front_sel !== mfront) begin
                errors++;
                $display("[TB] FAIL %s swap at clear end: got done=%b fs=%b expected done=0 fs=%b",
                         tag, swap_done, front_sel, mfront);
            end
            step();
            mfront = ~mfront;
            if (swap_done !== 1'b1 || front_sel !== mfront) begin
                errors++;
                $display("[TB] FAIL %s deferred swap: got done=%b fs=%b expected done=1 fs=%b",
                         tag, swap_done, front_sel, mfront);
            end
        end
    endtask

    task automatic do_clear(input string tag, input int wr_at, input int swap_at);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        run_sweep(tag, wr_at, swap_at);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        mfront = 1'b0;
        checks += 7;
        if (front_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset front_sel: got %b expected 0", front_sel); end
        if (rd_data !== '0) begin errors++; $display("[TB] FAIL reset rd_data: got %0h expected 0", rd_data); end
        if (rd_dv !== 1'b0) begin errors++; $display("[TB] FAIL reset rd_dv: got %b expected 0", rd_dv); end
        if (rd_oor !== 1'b0) begin errors++; $display("[TB] FAIL reset rd_oor: got %b expected 0", rd_oor); end
        if (swap_done !== 1'b0) begin errors++; $display("[TB] FAIL reset swap_done: got %b expected 0", swap_done); end
        if (clear_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset clear_busy: got %b expected 0", clear_busy); end
        if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset wr_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_clear_sweep();
        do_clear("clear_sweep", 11, 500);
        readback("clear_readback");
        do_clear("clear_other", -1, -1);
    endtask

    task automatic test_basic_swap();
        int a[$];
        a.push_back(5);
        write_px(5, 24'h112233);
        read_stream(a, "basic_old_front");
        do_swap("basic_swap");
        read_stream(a, "basic_new_front");
    endtask

    task automatic test_back_to_back();
        int a[$];
        for (int i = 0; i < 10; i++) begin
            write_px(i, COLOR_W'(i * 24'h010101));
            a.push_back(i);
        end
        do_swap("b2b_swap");
        read_stream(a, "b2b_read");
    endtask

    task automatic test_out_of_range();
        int a[$];
        a.push_back(1000);
        a.push_back(16'hFFFF);
        a.push_back(999);
        a.push_back(0);
        a.push_back(1000);
        read_stream(a, "oor_read");
        write_px(1000, COLOR_W'($urandom));
        write_px(16'hFFFF, COLOR_W'($urandom));
        readback("oor_front");
        do_swap("oor_swap");
        readback("oor_back");
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic pend;
        logic done_exp;
        logic dv_exp;
        pend = 1'b0;
        for (int c = 0; c < 403; c++) begin
            if (c < 400) begin
                wr_en    = ($urandom_range(0, 1) == 1);
                wr_addr  = ADDR_W'($urandom_range(0, 1049));
                wr_data  = COLOR_W'($urandom);
                rd_en    = ($urandom_range(0, 2) != 0);
                rd_addr  = ADDR_W'($urandom_range(0, 1049));
                swap_req = ($urandom_range(0, 15) == 0);
            end else begin
                wr_en    = 1'b0;
                rd_en    = 1'b0;
                swap_req = 1'b0;
            end
            if (rd_en) q.push_back(expect_read(int'(rd_addr), c + 2));
            if (wr_en && int'(wr_addr) < NUM_LEDS) model[~mfront][wr_addr] = wr_data;
            done_exp = pend;
            if (pend) begin
                mfront = ~mfront;
                pend   = 1'b0;
            end else if (swap_req) begin
                pend = 1'b1;
            end
            step();
            dv_exp = (q.size() > 0 && q[0].due == c);
            checks += 3;
            if (front_sel !== mfront) begin
                errors++;
                $display("[TB] FAIL random front_sel cycle %0d: got %b expected %b", c, front_sel, mfront);
            end
            if (swap_done !== done_exp) begin
                errors++;
                $display("[TB] FAIL random swap_done cycle %0d: got %b expected %b", c, swap_done, done_exp);
            end
            if (rd_dv !== dv_exp) begin
                errors++;
                $display("[TB] FAIL random rd_dv cycle %0d: got %b expected %b", c, rd_dv, dv_exp);
            end
            if (dv_exp) begin
                e = q.pop_front();
                checks += 2;
                if (rd_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL random rd_data cycle %0d: got %0h expected %0h", c, rd_data, e.data);
                end
                if (rd_oor !== e.oor) begin
                    errors++;
                    $display("[TB] FAIL random rd_oor cycle %0d: got %b expected %b", c, rd_oor, e.oor);
                end
            end
        end
        readback("random_front");
    endtask

    task automatic test_swap_and_clear();
        for (int i = 0; i < 50; i++) write_px(i, COLOR_W'($urandom) | 24'h000001);
        do_swap("sc_prep_swap");
        clear_req = 1'b1;
        swap_req  = 1'b1;
        step();
        clear_req = 1'b0;
        swap_req  = 1'b0;
        checks += 2;
        if (front_sel !== mfront || clear_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_clear edge1: got fs=%b busy=%b expected fs=%b busy=0", front_sel, clear_busy, mfront);
        end
        step();
        mfront = ~mfront;
        if (front_sel !== mfront || swap_done !== 1'b1 || clear_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_clear edge2: got fs=%b done=%b busy=%b expected fs=%b done=1 busy=0",
                     front_sel, swap_done, clear_busy, mfront);
        end
        step();
        checks++;
        if (clear_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL swap_clear busy rise: got %b expected 1", clear_busy);
        end
        run_sweep("swap_clear", -1, -1);
        readback("swap_clear_front");
        do_swap("swap_clear_swap");
        readback("swap_clear_zeroed");
    endtask

    task automatic test_reset_mid_clear();
        logic cb;
        for (int a = 0; a < NUM_LEDS; a++) write_px(a, COLOR_W'($urandom) | 24'h800000);
        cb = ~mfront;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (500) step();
        checks++;
        if (clear_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midclear busy before reset: got %b expected 1", clear_busy);
        end
        for (int a = 0; a < 500; a++) model[cb][a] = CLEAR_VAL;
        reset_n = 1'b0;
        #1;
        checks += 7;
        if (front_sel !== 1'b0) begin errors++; $display("[TB] FAIL midclear front_sel: got %b expected 0", front_sel); end
        if (rd_data !== '0) begin errors++; $display("[TB] FAIL midclear rd_data: got %0h expected 0", rd_data); end
        if (rd_dv !== 1'b0) begin errors++; $display("[TB] FAIL midclear rd_dv: got %b expected 0", rd_dv); end
        if (rd_oor !== 1'b0) begin errors++; $display("[TB] FAIL midclear rd_oor: got %b expected 0", rd_oor); end
        if (swap_done !== 1'b0) begin errors++; $display("[TB] FAIL midclear swap_done: got %b expected 0", swap_done); end
        if (clear_busy !== 1'b0) begin errors++; $display("[TB] FAIL midclear clear_busy: got %b expected 0", clear_busy); end
        if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL midclear wr_ready: got %b expected 1", wr_ready); end
        step();
        step();
        reset_n = 1'b1;
        mfront  = 1'b0;
        step();
        if (cb != mfront) do_swap("midclear_swap");
        readback("midclear_readback");
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        swap_req  = 1'b0;
        clear_req = 1'b0;
        mfront    = 1'b0;
        test_reset();
        test_clear_sweep();
        test_basic_swap();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_swap_and_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
